// File: rtl/cpu_controller_if.sv
// Datapath strobe bundle between the phase sequencer (master) and the CPU datapath (slave).
interface cpu_controller_if #(
  parameter int unsigned OPCODE_W = 3
);
  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                sel;
  logic                rd;
  logic                wr;
  logic                ld_ir;
  logic                ld_ac;
  logic                inc_pc;
  logic                ld_pc;
  logic                data_e;
  logic                halt;

  modport master (
    input  opcode, zero,
    output sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt
  );

  modport slave (
    output opcode, zero,
    input  sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt
  );
endinterface

// File: rtl/cpu_controller.sv
// 8-phase instruction sequencer and strobe decoder for the 5-bit-address RISC CPU.
// Optional CPU_CONTROLLER_SINGLE_STEP_EN adds a run input that gates leaving INST_ADDR.
module cpu_controller #(
  parameter int unsigned OPCODE_W = 3
) (
  input logic clk,
  input logic rst_n,
`ifdef CPU_CONTROLLER_SINGLE_STEP_EN
  input logic run,
`endif
  cpu_controller_if.master bus
);

  typedef enum logic [2:0] {
    StInstAddr  = 3'd0,
    StInstFetch = 3'd1,
    StInstLoad  = 3'd2,
    StIdle      = 3'd3,
    StOpAddr    = 3'd4,
    StOpFetch   = 3'd5,
    StAluOp     = 3'd6,
    StStore     = 3'd7
  } phase_e;

  localparam logic [OPCODE_W-1:0] OpHlt = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OpSkz = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OpAdd = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OpAnd = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OpXor = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OpLda = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OpSto = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OpJmp = OPCODE_W'(7);

  phase_e phase_q, phase_d;
  logic   halted_q, halted_d;

  logic is_hlt, is_skz, is_sto, is_jmp, alu_op;

  assign is_hlt = (bus.opcode == OpHlt);
  assign is_skz = (bus.opcode == OpSkz);
  assign is_sto = (bus.opcode == OpSto);
  assign is_jmp = (bus.opcode == OpJmp);
  assign alu_op = (bus.opcode == OpAdd) || (bus.opcode == OpAnd) ||
                  (bus.opcode == OpXor) || (bus.opcode == OpLda);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= StInstAddr;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Halting freezes the phase at OP_ADDR; only reset leaves the halted state.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (phase_q == StOpAddr && is_hlt) begin
        halted_d = 1'b1;
      end else begin
        phase_d = phase_e'(phase_q + 3'd1);
      end
`ifdef CPU_CONTROLLER_SINGLE_STEP_EN
      if (phase_q == StInstAddr && !run) begin
        phase_d = StInstAddr;
      end
`endif
    end
  end

  always_comb begin
    bus.sel    = 1'b0;
    bus.rd     = 1'b0;
    bus.wr     = 1'b0;
    bus.ld_ir  = 1'b0;
    bus.ld_ac  = 1'b0;
    bus.inc_pc = 1'b0;
    bus.ld_pc  = 1'b0;
    bus.data_e = 1'b0;
    bus.halt   = 1'b0;
    if (halted_q) begin
      bus.halt = 1'b1;
    end else begin
      unique case (phase_q)
        StInstAddr: begin
          bus.sel = 1'b1;
        end
        StInstFetch: begin
          bus.sel = 1'b1;
          bus.rd  = 1'b1;
        end
        StInstLoad, StIdle: begin
          bus.sel   = 1'b1;
          bus.rd    = 1'b1;
          bus.ld_ir = 1'b1;
        end
        StOpAddr: begin
          bus.halt   = is_hlt;
          bus.inc_pc = !is_hlt;
        end
        StOpFetch: begin
          bus.rd = alu_op;
        end
        StAluOp: begin
          bus.rd     = alu_op;
          bus.inc_pc = is_skz && bus.zero;
          bus.ld_pc  = is_jmp;
          bus.data_e = is_sto;
        end
        StStore: begin
          bus.rd     = alu_op;
          bus.ld_ac  = alu_op;
          bus.ld_pc  = is_jmp;
          bus.wr     = is_sto;
          bus.data_e = is_sto;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Randomized bench for cpu_controller against a step-counting reference model.
module tb_cpu_controller;

  logic clk;
  logic rst_n;
  logic run_v;
`ifdef CPU_CONTROLLER_SINGLE_STEP_EN
  logic run;
`endif

  cpu_controller_if #(.OPCODE_W(3)) bus ();

  cpu_controller #(.OPCODE_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef CPU_CONTROLLER_SINGLE_STEP_EN
    .run   (run),
`endif
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int m_step   = 0;   // position within the 8-cycle instruction
  bit m_halted = 1'b0;

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output vector order: sel rd wr ld_ir ld_ac inc_pc ld_pc data_e halt
  function automatic logic [8:0] outs();
    return {bus.sel, bus.rd, bus.wr, bus.ld_ir, bus.ld_ac, bus.inc_pc, bus.ld_pc,
            bus.data_e, bus.halt};
  endfunction

  function automatic logic [8:0] model_out(int step, bit halted, logic [2:0] op, logic z);
    bit alu = (op >= 3'd2) && (op <= 3'd5);
    bit s, r, w, ir, ac, ipc, lpc, de, h;
    if (halted) return 9'b0_0000_0001;
    s   = (step <= 3);
    r   = (step >= 1 && step <= 3) || (step >= 5 && alu);
    w   = (step == 7) && (op == 3'd6);
    ir  = (step == 2) || (step == 3);
    ac  = (step == 7) && alu;
    ipc = (step == 4 && op != 3'd0) || (step == 6 && op == 3'd1 && z);
    lpc = (step == 6 || step == 7) && (op == 3'd7);
    de  = (step == 6 || step == 7) && (op == 3'd6);
    h   = (step == 4) && (op == 3'd0);
    return {s, r, w, ir, ac, ipc, lpc, de, h};
  endfunction

  // Called just after a rising edge; checks mid-cycle, then advances the model.
  task automatic do_cycle(input logic [2:0] op, input logic z);
    bus.opcode = op;
    bus.zero   = z;
`ifdef CPU_CONTROLLER_SINGLE_STEP_EN
    run_v = ($urandom_range(0, 2) != 0);
    run   = run_v;
`endif
    #4;
    check($sformatf("step%0d_h%0d_op%0d_z%0d", m_step, m_halted, op, z), outs(),
          model_out(m_step, m_halted, op, z));
    check("excl", {7'd0, (bus.inc_pc & bus.ld_pc), (bus.wr & ~bus.data_e)}, 9'd0);
    @(posedge clk);
    #1;
    if (!m_halted) begin
      if (m_step == 4 && op == 3'd0) m_halted = 1'b1;
      else if (!(m_step == 0 && !run_v)) m_step = (m_step + 1) % 8;
    end
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_async"}, outs(), 9'b1_0000_0000);
    m_step   = 0;
    m_halted = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_held"}, outs(), 9'b1_0000_0000);
    rst_n = 1'b1;
  endtask

  // zmode: 0/1 fixed zero flag, 2 random
  task automatic run_instr(input logic [2:0] op, input int zmode);
    int guard = 0;
    do begin
      logic [2:0] o;
      logic z;
      o = (m_step < 3) ? 3'($urandom) : op;
      z = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      do_cycle(o, z);
      guard++;
    end while (m_step != 0 && !m_halted && guard < 64);
    if (guard >= 64) check("instr_timeout", 9'd1, 9'd0);
    if (m_halted) begin
      for (int i = 0; i < 20; i++) do_cycle((i % 2 == 0) ? 3'd2 : 3'($urandom), 1'($urandom));
      #1;
      reset_pulse("halt_reset");
    end
  endtask

  task automatic reset_mid();
    int guard = 0;
    while (m_step != 5 && guard < 64) begin
      do_cycle(3'd2, 1'b0);
      guard++;
    end
    if (guard >= 64) check("mid_timeout", 9'd1, 9'd0);
    #2;
    reset_pulse("mid_reset");
  endtask

  initial begin
    logic [2:0] directed [9];
    directed = '{3'd2, 3'd6, 3'd7, 3'd1, 3'd1, 3'd3, 3'd4, 3'd5, 3'd0};
    run_v      = 1'b1;
`ifdef CPU_CONTROLLER_SINGLE_STEP_EN
    run        = 1'b1;
`endif
    bus.opcode = 3'd0;
    bus.zero   = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs(), 9'b1_0000_0000);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_instr(directed[i], (i == 3) ? 1 : 0);
    reset_mid();
    for (int i = 0; i < 60; i++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 9) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      run_instr(op, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Phase sequencer for the 5-bit-address RISC CPU. It advances an 8-phase instruction cycle and decodes the current opcode, phase and accumulator zero flag into the datapath strobes.
- It drives the program counter (inc_pc, ld_pc), the address mux (sel), memory (rd, wr), the instruction register (ld_ir), the accumulator (ld_ac) and the data bus driver (data_e).
- It sits between the instruction register and all datapath load/enable inputs.

Parameters:
- OPCODE_W, 3, opcode width. Fixed at 3; any other value is unsupported.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  3  opcode field from instruction register.
- zero  input  1  accumulator-zero flag, high when the accumulator is 0.
- sel  output  1  address mux select: 1 = pc_addr, 0 = ir_addr.
- rd  output  1  memory read enable.
- wr  output  1  memory write strobe.
- ld_ir  output  1  instruction register load.
- ld_ac  output  1  accumulator load.
- inc_pc  output  1  program counter increment.
- ld_pc  output  1  program counter load from ir_addr.
- data_e  output  1  accumulator-to-data-bus driver enable.
- halt  output  1  CPU halted indicator.

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous and active-low.
- Opcode encoding: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. ALUOP = ADD|AND|XOR|LDA.
- State: 3-bit phase register plus a 1-bit halted flag.
- Phase order: INST_ADDR(0) -> INST_FETCH(1) -> INST_LOAD(2) -> IDLE(3) -> OP_ADDR(4) -> OP_FETCH(5) -> ALU_OP(6) -> STORE(7).
  - The phase advances by one every rising clk edge.
  - STORE wraps to INST_ADDR.
  - One instruction takes exactly 8 cycles.
- Reset (rst_n low, at any time):
  - phase = INST_ADDR and halted = 0, immediately without waiting for a clock edge.
  - Outputs during and after reset: sel=1; all other outputs 0.
  - Reset mid-instruction abandons that instruction; no strobe is asserted in the cycle after reset release except sel.
- Outputs are combinational decodes of phase, opcode, zero and halted (zero-latency Moore/Mealy mix). Any output not listed below for a phase is 0.
  - INST_ADDR: sel=1.
  - INST_FETCH: sel=1, rd=1.
  - INST_LOAD: sel=1, rd=1, ld_ir=1.
  - IDLE: sel=1, rd=1, ld_ir=1.
  - OP_ADDR:
    - opcode != HLT: inc_pc=1.
    - opcode == HLT: halt=1, inc_pc=0; halted is set at the next edge.
  - OP_FETCH: rd=ALUOP.
  - ALU_OP: rd=ALUOP; inc_pc=(SKZ && zero); ld_pc=JMP; data_e=STO.
  - STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=JMP; wr=STO; data_e=STO.
- Mutual exclusion:
  - inc_pc and ld_pc are never high in the same cycle.
  - wr is never high without data_e.
- Halted mode (halted=1):
  - Phase register frozen at OP_ADDR.
  - halt=1; all other outputs 0 (sel=0).
  - Only rst_n clears it; opcode and zero changes are ignored.
- SKZ: zero is sampled combinationally during ALU_OP only. With zero=1, the PC increments twice in the instruction (OP_ADDR and ALU_OP), skipping one word.
- opcode must be stable from IDLE through STORE; it is not sampled in INST_ADDR..INST_LOAD.

Optional Feature:
- Macro: CPU_CONTROLLER_SINGLE_STEP_EN.
- When defined:
  - Adds input port run (1 bit).
  - In INST_ADDR, the phase holds while run=0 and advances only on an edge where run=1.
  - Outputs while stalled equal the INST_ADDR outputs (sel=1).
  - run is ignored in all other phases and while halted.
- When undefined: no run port; the phase advances unconditionally.

Test Plan:
- Reset: rst_n=0 asserted asynchronously mid-phase 5, then released -> phase=INST_ADDR at once; sel=1, other outputs 0; rd=1 first appears 1 cycle after release.
- ADD (opcode=2), zero=0 -> 8-cycle sequence:
  - ld_ir high in cycles 2–3.
  - inc_pc high only in cycle 4.
  - rd high in cycles 1–3 and 5–7.
  - ld_ac high in cycle 7.
  - Returns to INST_ADDR at cycle 8.
- STO (opcode=6) -> data_e high in cycles 6–7, wr high only in cycle 7, rd low in cycles 5–7, ld_ac never high.
- JMP (opcode=7) -> ld_pc high in cycles 6–7, inc_pc high only in cycle 4.
- SKZ (opcode=1):
  - zero=1 -> inc_pc high in cycles 4 and 6.
  - zero=0 -> inc_pc high only in cycle 4.
- HLT (opcode=0):
  - Cycle 4: halt=1, inc_pc=0.
  - For 20 more cycles: halt stays 1, all other outputs 0, phase frozen; changing opcode to 2 has no effect.
  - rst_n pulse -> resumes at INST_ADDR with halt=0.
- (CPU_CONTROLLER_SINGLE_STEP_EN) run=0 -> phase holds at INST_ADDR for 5 cycles with sel=1; run pulsed high for one cycle -> full 8-phase sequence follows, then stall again at INST_ADDR.
